// File: rtl/ifetch_line_reader_if.sv
// Bus bundle for the instruction-fetch line reader: the core-side fetch
// handshake (req/gnt/rvalid) and the wide RAM read port it drives.
interface ifetch_line_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 128
);
  // Core instruction port
  logic                  instr_req_i;
  logic [31:0]           instr_addr_i;
  logic                  instr_gnt_o;
  logic                  instr_rvalid_o;
  logic [31:0]           instr_rdata_o;
  // RAM port A (read-only from this block's point of view)
  logic                  mem_en_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [LINE_WIDTH-1:0] mem_rdata_i;

  // The line reader itself
  modport slave (
    input  instr_req_i, instr_addr_i, mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, mem_en_o, mem_addr_o
  );

  // The surrounding core / RAM
  modport master (
    output instr_req_i, instr_addr_i, mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, mem_en_o, mem_addr_o
  );
endinterface

// File: rtl/ifetch_line_reader.sv
// Instruction-fetch line reader: two fully associative line buffers with LRU
// replacement. Hits are granted in the request cycle; misses issue one
// line read, fill a buffer the following cycle and then hit.
module ifetch_line_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  ifetch_line_reader_if.slave bus
);

  localparam int LINE_OFF = $clog2(LINE_WIDTH / 8);
  localparam int TAG_W    = ADDR_WIDTH - LINE_OFF;
  localparam int WORDS    = LINE_WIDTH / 32;
  localparam int WSEL_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state_reg, state_next;
  logic [1:0]            valid_reg;
  logic [TAG_W-1:0]      tag_reg  [2];
  logic [LINE_WIDTH-1:0] line_reg [2];
  logic                  lru_reg;
  logic [TAG_W-1:0]      fill_tag_reg;
  logic                  rvalid_reg;
  logic [31:0]           rdata_reg;

  logic [TAG_W-1:0]      req_tag;
  logic [WSEL_W-1:0]     word_sel;
  logic [1:0]            match;
  logic                  hit_idx;
  logic                  victim;
  logic                  fill_we;
  logic [31:0]           line_words [WORDS];

  logic                  gnt;
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;

  assign req_tag = bus.instr_addr_i[ADDR_WIDTH-1:LINE_OFF];

  generate
    if (WORDS > 1) begin : g_wsel
      assign word_sel = bus.instr_addr_i[LINE_OFF-1:2];
    end else begin : g_wsel_single
      assign word_sel = '0;
    end
  endgenerate

  // Address bits that never influence the lookup
  generate
    if (ADDR_WIDTH < 32) begin : g_unused_hi
      logic unused_addr_bits;
      assign unused_addr_bits = ^{bus.instr_addr_i[31:ADDR_WIDTH], bus.instr_addr_i[1:0]};
    end else begin : g_unused_lo
      logic unused_addr_bits;
      assign unused_addr_bits = ^bus.instr_addr_i[1:0];
    end
  endgenerate

  // Per-entry tag compare; a line is never resident twice, so at most one bit is set
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] && (tag_reg[gi] == req_tag);
    end
  endgenerate

  assign hit_idx = match[1];

  // Split the hitting line into 32-bit words for the word-select mux
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_words
      assign line_words[gi] = line_reg[hit_idx][gi*32 +: 32];
    end
  endgenerate

  // Victim: first invalid entry, otherwise the least recently used one
  always_comb begin
    victim = lru_reg;
    if (!valid_reg[0]) begin
      victim = 1'b0;
    end else if (!valid_reg[1]) begin
      victim = 1'b1;
    end
  end

  // A fill is discarded when flushed or reset in the same cycle
  assign fill_we = (state_reg == FILL) && !flush_i && !rst_i;

  // Next-state and combinational handshake outputs
  always_comb begin
    state_next = state_reg;
    gnt        = 1'b0;
    mem_en     = 1'b0;
    mem_addr   = '0;
    case (state_reg)
      IDLE: begin
        if (bus.instr_req_i && !flush_i) begin
          if (|match) begin
            gnt = 1'b1;
          end else begin
            mem_en     = 1'b1;
            mem_addr   = {req_tag, {LINE_OFF{1'b0}}};
            state_next = FILL;
          end
        end
      end
      FILL: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Entry bookkeeping: valid bits, LRU pointer and the tag of the pending fill
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg    <= '0;
      lru_reg      <= 1'b0;
      fill_tag_reg <= '0;
    end else begin
      if (mem_en) begin
        fill_tag_reg <= req_tag;
      end
      if (fill_we) begin
        valid_reg[victim] <= 1'b1;
        lru_reg           <= ~victim;
      end else if (gnt) begin
        lru_reg <= ~hit_idx;
      end
      // Flush wins over a same-cycle fill
      if (flush_i) begin
        valid_reg <= '0;
      end
    end
  end

  // Line and tag storage; contents only matter while the entry is valid
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      line_reg[victim] <= bus.mem_rdata_i;
      tag_reg[victim]  <= fill_tag_reg;
    end
  end

  // Response: one rvalid pulse per grant, data held until the next grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      rvalid_reg <= gnt;
      if (gnt) begin
        rdata_reg <= line_words[word_sel];
      end
    end
  end

  assign bus.instr_gnt_o    = gnt;
  assign bus.instr_rvalid_o = rvalid_reg;
  assign bus.instr_rdata_o  = rdata_reg;
  assign bus.mem_en_o       = mem_en;
  assign bus.mem_addr_o     = mem_addr;

endmodule

// File: doc/ifetch_line_reader.md
Name: ifetch_line_reader

Overview:
- Instruction-fetch initiator between the core's instruction port (req/gnt/rvalid) and the wide read port A of the dual-port RAM (en/addr/LINE_WIDTH-bit rdata, fixed 1-cycle read latency).
- Holds two LINE_WIDTH-bit line buffers with tags and LRU replacement.
- Serves word fetches from the buffers and refills lines on a miss.
- flush_i invalidates both buffers, e.g. after data-port stores to code (fence.i).

Parameters:
ADDR_WIDTH, 8, byte-address width of the RAM; memory wraps at 2**ADDR_WIDTH.
LINE_WIDTH, 128, line width in bits; power of two, at least 32; LINE_OFF = log2(LINE_WIDTH/8).

Ports:
clk_i  in  1  clock; all state changes on the rising edge.
rst_i  in  1  synchronous reset, active-high.
flush_i  in  1  invalidate both line buffers.
instr_req_i  in  1  core fetch request; held with the address until granted.
instr_addr_i  in  32  byte address; bits [1:0] and bits above ADDR_WIDTH-1 ignored.
instr_gnt_o  out  1  request accepted this cycle.
instr_rvalid_o  out  1  instr_rdata_o valid; one cycle after gnt.
instr_rdata_o  out  32  fetched word.
mem_en_o  out  1  RAM port-A read enable.
mem_addr_o  out  ADDR_WIDTH  line-aligned RAM byte address.
mem_rdata_i  in  LINE_WIDTH  RAM line data, valid the cycle after mem_en_o; byte k of the line sits at bits [8k+:8].

Behaviour:
- Address split: tag = addr[ADDR_WIDTH-1:LINE_OFF]; word select = addr[LINE_OFF-1:2].
- Entry state: valid[1:0], tag[1:0], line[1:0], lru bit (the index of the entry to replace next).
- State machine:
  - IDLE:
    - Hit when instr_req_i & !flush_i & a valid entry tag matches. instr_gnt_o=1 combinationally; the selected word is registered into instr_rdata_o; instr_rvalid_o=1 next cycle; lru := other entry.
    - Miss when instr_req_i & !flush_i & no match. mem_en_o=1 and mem_addr_o={tag,LINE_OFF zeros} combinationally; instr_gnt_o=0; go to FILL.
  - FILL: capture mem_rdata_i into the victim entry, set its tag and valid, lru := other entry, return to IDLE. instr_gnt_o=0 and mem_en_o=0. The held request then hits in IDLE.
- Victim selection: entry 0 if invalid, else entry 1 if invalid, else the lru entry.
- Latency:
  - Hit: gnt in cycle 0, rvalid in cycle 1.
  - Miss: mem_en_o in cycle 0, fill in cycle 1, gnt in cycle 2, rvalid in cycle 3.
- instr_rvalid_o is a 1-cycle pulse per gnt. instr_rdata_o holds its last value until the next rvalid.
- Outputs are 0 when idle: mem_en_o and mem_addr_o=0 when no miss is issued; instr_gnt_o=0 when not hitting.
- flush_i:
  - Clears both valid bits at the clock edge and blocks gnt and mem_en_o in that cycle.
  - Asserted during FILL: the fill is discarded (valid stays 0), state returns to IDLE, lru is unchanged.
  - An rvalid already scheduled for the following cycle still occurs.
- Reset (including mid-FILL): state=IDLE, valid=0, lru=0, instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0, mem_en_o=0, mem_addr_o=0. Tags and lines are don't-care. In-flight fill data is dropped.
- Request dropped before gnt: no response; a started FILL still completes into the buffer.
- A single line never occupies both entries, because fills occur only on a miss.

Test Plan:
- Preload: every RAM byte at address k holds k[7:0]; ADDR_WIDTH=8, LINE_WIDTH=128.
- Cold miss: reset, req addr 0x14 -> cycle 0: mem_en_o=1, mem_addr_o=0x10; gnt in cycle 2; rvalid in cycle 3 with rdata 0x17161514.
- Hit: next req 0x18 -> gnt the same cycle, mem_en_o stays 0, rvalid next cycle with 0x1B1A1918.
- LRU: fill 0x00 then 0x10, hit 0x04, miss 0x20 -> line 0x10 evicted. Then 0x08 hits with no mem_en_o; 0x10 misses with mem_addr_o=0x10.
- Flush: with lines 0x00/0x10 valid, flush_i=1 with req 0x04 -> no gnt that cycle. Next cycle: mem_en_o=1, mem_addr_o=0x00; rvalid three cycles later with 0x07060504.
- Reset mid-fill: miss on 0x24, rst_i=1 in the FILL cycle -> no gnt or rvalid, all outputs 0. A repeated req 0x24 misses again and returns 0x27262524.
- Wrap: req 0x1F4 -> mem_addr_o=0xF0, rdata 0xF7F6F5F4. A following req 0x0F8 hits in the same line, returning 0xFBFAF9F8.
